chip_link_host: RTL



---
 rtl/chip_link_pkg.sv | 35 +++
 rtl/chip_link_res_fifo.sv | 58 +++++
 rtl/chip_link_host.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/chip_link_pkg.sv
// chip_link_pkg: shared types for the host side of the three-bus chip link.
//   link_state_e  - bus-direction FSM states
//   res_entry_t   - one captured result (three data words + coordinates),
//                   sized for the default link geometry
//   clog2_min1    - $clog2 that never returns 0, for 1-entry dimensions
package chip_link_pkg;

    localparam int IO_DATA_WIDTH_DEF      = 16;
    localparam int FEATURE_MAP_WIDTH_DEF  = 1024;
    localparam int FEATURE_MAP_HEIGHT_DEF = 1024;
    localparam int OUTPUT_NB_CHANNELS_DEF = 64;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int X_W  = clog2_min1(FEATURE_MAP_WIDTH_DEF);
    localparam int Y_W  = clog2_min1(FEATURE_MAP_HEIGHT_DEF);
    localparam int CH_W = clog2_min1(OUTPUT_NB_CHANNELS_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        RECV  = 2'd2,
        GUARD = 2'd3
    } link_state_e;

    typedef struct packed {
        logic [3*IO_DATA_WIDTH_DEF-1:0] data;  // {con_3, con_2, con_1}
        logic [X_W-1:0]                 x;
        logic [Y_W-1:0]                 y;
        logic [CH_W-1:0]                ch;
    } res_entry_t;

endpackage

// File: rtl/chip_link_res_fifo.sv
// chip_link_res_fifo: synchronous result FIFO.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data write request and entry
//   pop             read request (ignored when empty)
//   head            entry at the read pointer
//   empty           no entries held
//   drop            push refused because the FIFO was full and not popping
// A push into a full FIFO succeeds when a pop happens in the same cycle.
module chip_link_res_fifo
    import chip_link_pkg::*;
#(
    parameter type entry_t = res_entry_t,
    parameter int  DEPTH   = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   empty,
    output logic   drop
);

    localparam int AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit distinguishes full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/chip_link_host.sv
// chip_link_host: host side of the accelerator's three-bus link.
// Streams source beats onto con_1..con_3 (con_valid/con_ready), releases the
// buses whenever the chip asserts driving_cons, and captures the chip's
// result strobes into a FIFO since output_valid cannot be back-pressured.
// Ports:
//   clk, arst_in                   clock, asynchronous active-high reset
//   con_1..con_3                   bidirectional chip data buses
//   con_valid / con_ready          host->chip beat handshake
//   driving_cons                   chip owns the buses
//   output_valid, output_x/y/ch    chip result strobe and coordinates
//   src_valid/src_ready/src_data   source beats, {con_3,con_2,con_1}
//   res_valid/res_ready/res_data   result stream, same packing
//   res_x/res_y/res_ch             result coordinates
//   clr_err_in                     clears sticky flags (a new error wins)
//   proto_err, res_overflow        sticky error flags
//   stat_beats_sent, stat_results  counters, built only with
//                                  CHIP_LINK_HOST_STATS_EN, else tied to 0
module chip_link_host
    import chip_link_pkg::*;
#(
    parameter int IO_DATA_WIDTH      = 16,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int RES_FIFO_DEPTH     = 4
) (
    input  logic                                  clk,
    input  logic                                  arst_in,
    inout  wire  [IO_DATA_WIDTH-1:0]              con_1,
    inout  wire  [IO_DATA_WIDTH-1:0]              con_2,
    inout  wire  [IO_DATA_WIDTH-1:0]              con_3,
    output logic                                  con_valid,
    input  logic                                  con_ready,
    input  logic                                  driving_cons,
    input  logic                                  output_valid,
    input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
    input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
    input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch,
    input  logic                                  src_valid,
    output logic                                  src_ready,
    input  logic [3*IO_DATA_WIDTH-1:0]            src_data,
    output logic                                  res_valid,
    input  logic                                  res_ready,
    output logic [3*IO_DATA_WIDTH-1:0]            res_data,
    output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  res_x,
    output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] res_y,
    output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] res_ch,
    input  logic                                  clr_err_in,
    output logic                                  proto_err,
    output logic                                  res_overflow,
    output logic [31:0]                           stat_beats_sent,
    output logic [31:0]                           stat_results
);

    localparam int DW = IO_DATA_WIDTH;
    localparam int XW = $clog2(FEATURE_MAP_WIDTH);
    localparam int YW = $clog2(FEATURE_MAP_HEIGHT);
    localparam int CW = $clog2(OUTPUT_NB_CHANNELS);

    typedef struct packed {
        logic [3*DW-1:0] data;
        logic [XW-1:0]   x;
        logic [YW-1:0]   y;
        logic [CW-1:0]   ch;
    } entry_t;

    link_state_e     state;
    link_state_e     state_nx;
    logic [3*DW-1:0] hold_q;
    logic            hold_valid;
    logic            beat_done;
    logic            src_load;
    logic            res_push;
    logic            res_pop;
    logic            fifo_empty;
    logic            fifo_drop;
    logic            proto_set;
    entry_t          push_entry;
    entry_t          head_entry;

    // con_valid doubles as the bus output enable: the host drives exactly
    // while presenting a beat, and driving_cons / reset cut it off
    // combinationally so the release never waits for a clock edge.
    assign con_valid = !arst_in && (state == SEND) && hold_valid && !driving_cons;
    assign con_1     = con_valid ? hold_q[DW-1:0]      : {DW{1'bz}};
    assign con_2     = con_valid ? hold_q[2*DW-1:DW]   : {DW{1'bz}};
    assign con_3     = con_valid ? hold_q[3*DW-1:2*DW] : {DW{1'bz}};

    assign beat_done = con_valid && con_ready;
    assign src_ready = !arst_in && (!hold_valid || beat_done);
    assign src_load  = src_valid && src_ready;

    // Strobes are captured whenever the chip owns the buses; a strobe without
    // bus ownership carries no valid data and is only flagged.
    assign res_push  = output_valid && driving_cons;
    assign proto_set = (output_valid && !driving_cons) ||
                       ((state == SEND) && driving_cons && hold_valid);

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            hold_q     <= '0;
            hold_valid <= 1'b0;
        end else if (src_load) begin
            hold_q     <= src_data;
            hold_valid <= 1'b1;
        end else if (beat_done) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (driving_cons)                 state_nx = RECV;
                else if (hold_valid || src_load)  state_nx = SEND;
            end
            SEND: begin
                // A beat interrupted here stays in hold_q and is resent
                // after the GUARD/IDLE turnaround.
                if (driving_cons)                 state_nx = RECV;
                else if (!hold_valid && !src_load) state_nx = IDLE;
            end
            RECV: begin
                if (!driving_cons)                state_nx = GUARD;
            end
            GUARD:                                state_nx = IDLE;
            default:                              state_nx = IDLE;
        endcase
    end

    // Set has priority over clear so an error in the clearing cycle survives.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            proto_err    <= 1'b0;
            res_overflow <= 1'b0;
        end else begin
            if (proto_set)       proto_err <= 1'b1;
            else if (clr_err_in) proto_err <= 1'b0;
            if (fifo_drop)       res_overflow <= 1'b1;
            else if (clr_err_in) res_overflow <= 1'b0;
        end
    end

    assign push_entry = '{data: {con_3, con_2, con_1}, x: output_x, y: output_y, ch: output_ch};
    assign res_pop    = res_valid && res_ready;

    chip_link_res_fifo #(
        .entry_t (entry_t),
        .DEPTH   (RES_FIFO_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (arst_in),
        .push      (res_push),
        .push_data (push_entry),
        .pop       (res_pop),
        .head      (head_entry),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    assign res_valid = !fifo_empty;
    assign res_data  = head_entry.data;
    assign res_x     = head_entry.x;
    assign res_y     = head_entry.y;
    assign res_ch    = head_entry.ch;

`ifdef CHIP_LINK_HOST_STATS_EN
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            stat_beats_sent <= '0;
            stat_results    <= '0;
        end else begin
            if (beat_done) stat_beats_sent <= stat_beats_sent + 32'd1;
            if (res_push)  stat_results    <= stat_results + 32'd1;
        end
    end
`else
    assign stat_beats_sent = '0;
    assign stat_results    = '0;
`endif

endmodule
